// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and a per-register pending-write scoreboard.
// Latency: reads are combinational (zero cycles); writes and scoreboard updates land on the rising clk edge.
// Backpressure: none internally; decode uses rd_busy to stall on RAW hazards.
module regfile_mp #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*DW-1:0] wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic                 flush
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0][DW-1:0] regs_q;
    logic [DEPTH-1:0][DW-1:0] regs_d;
    logic [DEPTH-1:0]         busy_q;
    logic [DEPTH-1:0]         busy_d;

    // Next register contents: walk write ports in ascending order so the
    // youngest (highest-index) port wins on an address collision.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                regs_d[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
            end
        end
        regs_d[0] = '0;
    end

    // Scoreboard next state: writeback clears, issue sets (new producer
    // owns the register even if it was written back this cycle), flush
    // overrides everything.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en && (iss_addr != '0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset clears data and scoreboard asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: register 0 is hardwired zero, otherwise youngest matching
    // writer bypasses the array. A same-cycle writeback also hides the busy
    // bit since the value is already forwarded. Outputs are forced to zero
    // while reset is held so bypass cannot leak through during reset.
    always_comb begin
        logic [AW-1:0] ra;
        logic [DW-1:0] val;
        logic          hit;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra  = rd_addr[i*AW +: AW];
            val = regs_q[ra];
            hit = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
                    hit = 1'b1;
                    val = wr_data[j*DW +: DW];
                end
            end
            if (resetn && (ra != '0)) begin
                rd_data[i*DW +: DW] = val;
                rd_busy[i]          = busy_q[ra] && !hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, bypass, port priority, scoreboard, flush, async reset.
// Latency: inputs change 2 time units after a rising edge; combinational outputs checked 1 unit later.
// Backpressure: not applicable; all expected values are hand-computed constants.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic              clk;
    logic              resetn;
    logic [2*AW-1:0]   rd_addr;
    logic [2*DW-1:0]   rd_data;
    logic [1:0]        rd_busy;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*DW-1:0]   wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              flush;

    int checks;
    int errors;

    regfile_mp #(.DW(DW), .AW(AW), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic set_wr(input logic [1:0] en,
                          input logic [AW-1:0] a0, input logic [31:0] d0,
                          input logic [AW-1:0] a1, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        resetn   = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;

        // 1. reset: every address reads zero and not busy
        tick();
        for (int a = 0; a < 32; a++) begin
            set_rd(a[AW-1:0], 5'(31 - a));
            chk("rst_data0", rd_data[31:0], 32'h0);
            chk("rst_data1", rd_data[63:32], 32'h0);
            chk("rst_busy", {30'h0, rd_busy}, 32'h0);
        end
        // bypass must not leak while reset is held
        set_wr(2'b01, 5'd5, 32'hFFFF_FFFF, 5'd0, 32'h0);
        set_rd(5'd5, 5'd0);
        chk("rst_no_bypass", rd_data[31:0], 32'h0);
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        #1 resetn = 1'b1;
        tick();

        // 2. single write with same-cycle bypass, then read from array
        set_wr(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0);
        set_rd(5'd5, 5'd6);
        chk("byp_5", rd_data[31:0], 32'hDEAD_BEEF);
        chk("byp_6_untouched", rd_data[63:32], 32'h0);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd5);
        chk("arr_5_p0", rd_data[31:0], 32'hDEAD_BEEF);
        chk("arr_5_p1", rd_data[63:32], 32'hDEAD_BEEF);

        // 3. both ports hit addr 7: port 1 wins for bypass and storage
        set_wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
        set_rd(5'd7, 5'd5);
        chk("byp_7_prio", rd_data[31:0], 32'h22);
        chk("byp_other", rd_data[63:32], 32'hDEAD_BEEF);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd7, 5'd7);
        chk("arr_7_prio", rd_data[31:0], 32'h22);
        // writes to register 0 are ignored
        set_wr(2'b11, 5'd0, 32'h33, 5'd0, 32'h44);
        set_rd(5'd0, 5'd7);
        chk("r0_byp", rd_data[31:0], 32'h0);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd0, 5'd7);
        chk("r0_arr", rd_data[31:0], 32'h0);
        chk("arr_7_keep", rd_data[63:32], 32'h22);
        // two different addresses on the two ports
        set_wr(2'b11, 5'd8, 32'hA0A0_A0A0, 5'd31, 32'hB1B1_B1B1);
        set_rd(5'd8, 5'd31);
        chk("byp_8", rd_data[31:0], 32'hA0A0_A0A0);
        chk("byp_31", rd_data[63:32], 32'hB1B1_B1B1);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd8, 5'd31);
        chk("arr_8", rd_data[31:0], 32'hA0A0_A0A0);
        chk("arr_31", rd_data[63:32], 32'hB1B1_B1B1);

        // 4. issue to 9: busy visible next cycle, cleared by writeback
        iss_en = 1'b1; iss_addr = 5'd9;
        set_rd(5'd9, 5'd9);
        chk("iss_same_cycle", {30'h0, rd_busy}, 32'h0);
        tick();
        iss_en = 1'b0;
        set_rd(5'd9, 5'd8);
        chk("busy_9", {30'h0, rd_busy}, 32'h1);
        set_wr(2'b10, 5'd0, 32'h0, 5'd9, 32'h55);
        set_rd(5'd9, 5'd9);
        chk("wb_busy_hidden", {30'h0, rd_busy}, 32'h0);
        chk("wb_data_9", rd_data[31:0], 32'h55);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd9, 5'd9);
        chk("busy_9_clear", {30'h0, rd_busy}, 32'h0);
        chk("arr_9", rd_data[63:32], 32'h55);

        // 5. issue and writeback same cycle: issue wins
        iss_en = 1'b1; iss_addr = 5'd3;
        set_wr(2'b01, 5'd3, 32'h77, 5'd0, 32'h0);
        tick();
        iss_addr = 5'd12;
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd3, 5'd12);
        chk("iss_wins_busy3", {30'h0, rd_busy}, 32'h1);
        chk("iss_wins_data3", rd_data[31:0], 32'h77);
        tick();
        iss_en = 1'b0;
        set_rd(5'd3, 5'd12);
        chk("busy_3_12", {30'h0, rd_busy}, 32'h3);
        // flush beats a simultaneous issue
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        flush = 1'b0; iss_en = 1'b0;
        set_rd(5'd3, 5'd12);
        chk("flush_3_12", {30'h0, rd_busy}, 32'h0);
        set_rd(5'd4, 5'd0);
        chk("flush_4", {30'h0, rd_busy}, 32'h0);
        // issuing register 0 is ignored
        iss_en = 1'b1; iss_addr = 5'd0;
        tick();
        iss_en = 1'b0;
        set_rd(5'd0, 5'd4);
        chk("iss_r0", {30'h0, rd_busy}, 32'h0);

        // 6. async reset between edges clears state immediately
        iss_en = 1'b1; iss_addr = 5'd6;
        tick();
        iss_en = 1'b0;
        set_rd(5'd5, 5'd6);
        chk("pre_rst_data5", rd_data[31:0], 32'hDEAD_BEEF);
        chk("pre_rst_busy6", {30'h0, rd_busy}, 32'h2);
        resetn = 1'b0;
        #1;
        chk("arst_data5", rd_data[31:0], 32'h0);
        chk("arst_busy", {30'h0, rd_busy}, 32'h0);
        // a write attempted during reset must not land
        set_wr(2'b01, 5'd7, 32'hBAD0_BAD0, 5'd0, 32'h0);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        resetn = 1'b1;
        set_rd(5'd5, 5'd7);
        chk("post_rst_5", rd_data[31:0], 32'h0);
        chk("post_rst_7", rd_data[63:32], 32'h0);
        chk("post_rst_busy", {30'h0, rd_busy}, 32'h0);
        set_wr(2'b01, 5'd5, 32'h99, 5'd0, 32'h0);
        tick();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd0);
        chk("first_wr_after_rst", rd_data[31:0], 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
